// File: rtl/truth_table_checker_if.sv
// Signal bundle between the truth-table checker and the function block under test.
// The checker side is the master: it drives A/B/C and reports results, and samples start and the F outputs.
interface truth_table_checker_if;
  logic       start;
  logic       A;
  logic       B;
  logic       C;
  logic       F_structural;
  logic       F_functional;
  logic       F_behavioral;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic [7:0] mismatch_mask;
  logic [3:0] mismatch_count;
  logic       pass;

  modport master (
    input  start,
    input  F_structural,
    input  F_functional,
    input  F_behavioral,
    output A,
    output B,
    output C,
    output busy,
    output done,
    output truth_table,
    output mismatch_mask,
    output mismatch_count,
    output pass
  );

  modport slave (
    output start,
    output F_structural,
    output F_functional,
    output F_behavioral,
    input  A,
    input  B,
    input  C,
    input  busy,
    input  done,
    input  truth_table,
    input  mismatch_mask,
    input  mismatch_count,
    input  pass
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps {A,B,C} through 000..111, holding each vector DWELL cycles, and compares
// the three variants of the function block on the last cycle of each dwell.
module truth_table_checker #(
  parameter int unsigned DWELL = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_DWELL = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] tt_q, tt_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] count_q, count_d;
  logic       pass_q, pass_d;
  logic       disagree;

  assign disagree = !((bus.F_structural == bus.F_functional) &&
                      (bus.F_functional == bus.F_behavioral));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      dwell_q <= 8'd0;
      tt_q    <= 8'd0;
      mask_q  <= 8'd0;
      count_q <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    tt_d    = tt_q;
    mask_d  = mask_q;
    count_d = count_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = 3'd0;
          dwell_d = 8'd0;
          tt_d    = 8'd0;
          mask_d  = 8'd0;
          count_d = 4'd0;
          pass_d  = 1'b0;
        end
      end

      S_RUN: begin
        dwell_d = dwell_q + 8'd1;
        if (dwell_q == LAST_DWELL) begin
          tt_d[vec_q] = bus.F_behavioral;
          if (disagree) begin
            mask_d[vec_q] = 1'b1;
            count_d       = count_q + 4'd1;
          end
          dwell_d = 8'd0;
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
          end else begin
            // Final sample: verdict must include the count just updated above.
            state_d = S_DONE;
            vec_d   = 3'd0;
            pass_d  = (count_d == 4'd0);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // vec_q is held at zero outside RUN, so the outputs need no state gating.
  assign bus.A              = vec_q[2];
  assign bus.B              = vec_q[1];
  assign bus.C              = vec_q[0];
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.truth_table    = tt_q;
  assign bus.mismatch_mask  = mask_q;
  assign bus.mismatch_count = count_q;
  assign bus.pass           = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: two instances (DWELL=5 and DWELL=2) driven
// by a model of F=(A&B)|C with selectable fault injection.
module tb_truth_table_checker;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   mode;   // 0 clean, 1 structural fault at 011, 2 functional inverted everywhere

  truth_table_checker_if if5 ();
  truth_table_checker_if if2 ();

  truth_table_checker #(.DWELL(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5.master));
  truth_table_checker #(.DWELL(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic f5, f2;
  always_comb begin
    f5 = (if5.A & if5.B) | if5.C;
    if5.F_behavioral = f5;
    if5.F_structural = (mode == 1 && {if5.A, if5.B, if5.C} == 3'b011) ? ~f5 : f5;
    if5.F_functional = (mode == 2) ? ~f5 : f5;
  end
  always_comb begin
    f2 = (if2.A & if2.B) | if2.C;
    if2.F_behavioral = f2;
    if2.F_structural = (mode == 1 && {if2.A, if2.B, if2.C} == 3'b011) ? ~f2 : f2;
    if2.F_functional = (mode == 2) ? ~f2 : f2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 5) if5.start = v;
    else          if2.start = v;
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 5) ? if5.busy : if2.busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 5) ? if5.done : if2.done;
  endfunction

  function automatic logic [2:0] get_abc(input int sel);
    return (sel == 5) ? {if5.A, if5.B, if5.C} : {if2.A, if2.B, if2.C};
  endfunction

  // {pass, count, mask, truth_table}
  function automatic logic [20:0] get_res(input int sel);
    if (sel == 5) return {if5.pass, if5.mismatch_count, if5.mismatch_mask, if5.truth_table};
    return {if2.pass, if2.mismatch_count, if2.mismatch_mask, if2.truth_table};
  endfunction

  function automatic logic [25:0] get_all(input int sel);
    return {get_busy(sel), get_done(sel), get_abc(sel), get_res(sel)};
  endfunction

  task automatic sweep(input int sel, input int dw, input bit hold);
    set_start(sel, 1'b1);
    tick();
    if (!hold) set_start(sel, 1'b0);
    for (int j = 0; j < 8 * dw; j++) begin
      chk($sformatf("busy_d%0d_c%0d", dw, j), 32'(get_busy(sel)), 32'd1);
      chk($sformatf("abc_d%0d_c%0d", dw, j), 32'(get_abc(sel)), 32'(j / dw));
      tick();
    end
    chk($sformatf("end_d%0d", dw), 32'({get_busy(sel), get_done(sel), get_abc(sel)}), 32'b01000);
  endtask

  task automatic chk_res(input string tag, input int sel, input logic [7:0] tt,
                         input logic [7:0] mask, input logic [3:0] cnt, input logic p);
    chk({tag, "_tt"},    32'(get_res(sel) & 21'h0000FF), 32'(tt));
    chk({tag, "_mask"},  32'((get_res(sel) >> 8) & 21'hFF), 32'(mask));
    chk({tag, "_count"}, 32'((get_res(sel) >> 16) & 21'hF), 32'(cnt));
    chk({tag, "_pass"},  32'(get_res(sel) >> 20), 32'(p));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    mode      = 0;
    rst       = 1'b0;
    if5.start = 1'b0;
    if2.start = 1'b0;

    // 1: reset asserted mid-cycle, then idle with start low
    #12 rst = 1'b1;
    #1;
    chk("reset5", 32'(get_all(5)), 32'd0);
    chk("reset2", 32'(get_all(2)), 32'd0);
    #10 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle_c%0d", i), 32'(get_all(5)), 32'd0);
    end

    // 2: clean sweep
    mode = 0;
    sweep(5, 5, 1'b0);
    chk_res("clean", 5, 8'hEA, 8'h00, 4'd0, 1'b1);
    tick();
    chk("done_hold", 32'({get_done(5), get_res(5)}), 32'({1'b1, 1'b1, 4'd0, 8'h00, 8'hEA}));

    // 3: single fault at vector 011
    mode = 1;
    sweep(5, 5, 1'b0);
    chk_res("single", 5, 8'hEA, 8'h08, 4'd1, 1'b0);

    // 4: functional variant inverted everywhere
    mode = 2;
    sweep(5, 5, 1'b0);
    chk_res("allvec", 5, 8'hEA, 8'hFF, 4'd8, 1'b0);

    // 5: start held high through the sweep, then restart from DONE
    mode = 0;
    sweep(5, 5, 1'b1);
    chk_res("held", 5, 8'hEA, 8'h00, 4'd0, 1'b1);
    tick();
    chk("restart_flags", 32'({get_busy(5), get_done(5), get_abc(5)}), 32'b10000);
    chk("restart_clear", 32'(get_res(5)), 32'd0);
    set_start(5, 1'b0);
    for (int j = 1; j < 40; j++) begin
      tick();
      chk($sformatf("restart_busy_c%0d", j), 32'(get_busy(5)), 32'd1);
      chk($sformatf("restart_abc_c%0d", j), 32'(get_abc(5)), 32'(j / 5));
    end
    tick();
    chk("restart_done", 32'({get_busy(5), get_done(5)}), 32'b01);
    chk_res("restart", 5, 8'hEA, 8'h00, 4'd0, 1'b1);

    // 6: reset while ABC=101, then full sweeps at DWELL=5 and DWELL=2
    set_start(5, 1'b1);
    tick();
    set_start(5, 1'b0);
    begin
      int guard = 0;
      while (get_abc(5) != 3'b101 && guard < 60) begin
        tick();
        guard++;
      end
      chk("reach_101", 32'(get_abc(5)), 32'b101);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_all", 32'(get_all(5)), 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("post_abort_idle", 32'(get_all(5)), 32'd0);
    sweep(5, 5, 1'b0);
    chk_res("post_abort", 5, 8'hEA, 8'h00, 4'd0, 1'b1);
    sweep(2, 2, 1'b0);
    chk_res("dwell2", 2, 8'hEA, 8'h00, 4'd0, 1'b1);
    mode = 1;
    sweep(2, 2, 1'b0);
    chk_res("dwell2_single", 2, 8'hEA, 8'h08, 4'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Self-sequencing exhaustive checker for the three-variant combinational function block (structural, functional and behavioral outputs).
- Drives A, B and C through 000..111 after a start pulse.
- Holds each vector for DWELL cycles and samples the three F outputs on the last cycle of the dwell.
- Records the captured truth table and any disagreement between the three variants, then reports pass/fail with a done flag.

Parameters:
DWELL, 5, clock cycles each input vector is held; sampling occurs on the last cycle; legal range 2..255.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  level-sampled request to begin a sweep; honoured in IDLE or DONE only.
A  output  1  function input, MSB of the vector index.
B  output  1  function input, middle bit of the vector index.
C  output  1  function input, LSB of the vector index.
F_structural  input  1  structural-variant output of the function block.
F_functional  input  1  functional-variant output of the function block.
F_behavioral  input  1  behavioral-variant output of the function block.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next accepted start or reset.
truth_table  output  8  bit v holds the F_behavioral value sampled for vector v = {A,B,C}.
mismatch_mask  output  8  bit v set if the three F values disagreed at vector v.
mismatch_count  output  4  number of set bits in mismatch_mask, range 0..8.
pass  output  1  valid when done=1; equals (mismatch_count == 0).

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; A=B=C=0; busy=0; done=0; pass=0.
  - truth_table=0; mismatch_mask=0; mismatch_count=0.
  - Internal vector and dwell counters are set to 0.
- States: IDLE, RUN, DONE.
- IDLE: outputs hold. If start=1 at edge k, then after edge k:
  - state=RUN, busy=1, done=0, pass=0.
  - Vector counter=0, dwell counter=0, {A,B,C}=000.
  - truth_table, mismatch_mask and mismatch_count are cleared.
- RUN:
  - {A,B,C} always equals the vector counter.
  - The dwell counter increments every edge.
  - At the edge where dwell counter == DWELL-1 (sample edge), the F inputs present at that edge are captured:
    - truth_table[vec] <= F_behavioral.
    - If the three F values are not all equal: mismatch_mask[vec] <= 1 and mismatch_count increments.
    - If vec != 7: vec increments and the dwell counter returns to 0.
    - If vec == 7: state=DONE, busy=0, done=1, {A,B,C}=000, and pass is computed including this final sample.
- Timing: vector v is sampled at edge k+(v+1)*DWELL. busy is high for exactly 8*DWELL cycles. done rises after edge k+8*DWELL.
- start while in RUN is ignored; the sweep is not restarted.
- DONE: done and all results hold. start=1 restarts exactly as from IDLE: results are cleared and done drops on the following edge.
- rst asserted during RUN aborts immediately to reset values; no partial results are retained.
- F inputs are not synchronised; they are treated as combinational functions of A, B and C within the same clock domain.
- mismatch_count cannot overflow, since its maximum is 8 in a 4-bit field.

Test Plan:
1. Reset then idle: assert rst mid-cycle, release, hold start=0 for 20 cycles -> all outputs remain 0; busy=0, done=0.
2. Clean sweep, DWELL=5, all three F driven by the model F=(A&B)|C; pulse start -> busy high for 40 cycles; ABC steps 000..111 every 5 cycles; then done=1, truth_table=0xEA, mismatch_mask=0x00, mismatch_count=0, pass=1.
3. Single fault: same model but F_structural inverted only when ABC=011 -> truth_table=0xEA, mismatch_mask=0x08, mismatch_count=1, pass=0.
4. All-vector fault: F_functional tied to the inverse of the model -> mismatch_mask=0xFF, mismatch_count=8, pass=0.
5. start held high throughout a sweep -> the sweep is not restarted mid-run; after done, the next edge with start=1 clears results and begins a new 40-cycle sweep.
6. Reset mid-sweep: assert rst while ABC=101 -> all outputs are immediately 0; a subsequent start produces a full correct sweep (as in scenario 2), with DWELL=2 also checked: busy for 16 cycles, truth_table=0xEA.
